// File: rtl/prog_load_ctrl.sv
// Program-load controller: assembles little-endian words from a UART byte stream,
// writes them to instruction/data memory and holds the CPU in reset meanwhile.
module prog_load_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int IMEM_WORDS = 16384,
  parameter int DMEM_WORDS = 16384,
  parameter int TIMEOUT    = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              cpu_hold,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_RUN, S_HDR, S_IMEM, S_DMEM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        bidx;
  logic [23:0]       wbuf;
  logic [15:0]       icount, dcount;
  logic [ADDR_W:0]   wcnt;
  logic [TW-1:0]     tcnt;

  logic              imem_we_p1, dmem_we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  logic              loading, accept, byte_last, tmo;
  logic              hdr_bad, last_i, last_d;
  logic [15:0]       dcount_hdr;

  assign loading    = (state == S_HDR) || (state == S_IMEM) || (state == S_DMEM);
  assign accept     = rx_valid && loading;
  assign byte_last  = accept && (bidx == 2'd3);
  // Idle cycle that would bring the counter to TIMEOUT-1 aborts the load.
  assign tmo        = loading && !accept && (tcnt == TW'(TIMEOUT - 2));
  // dcount high byte arrives with header byte 3, so check the combined value.
  assign dcount_hdr = {rx_data, dcount[7:0]};
  assign hdr_bad    = ({16'd0, icount} > 32'(IMEM_WORDS)) ||
                      ({16'd0, dcount_hdr} > 32'(DMEM_WORDS));
  assign last_i     = (32'(wcnt) + 32'd1) == {16'd0, icount};
  assign last_d     = (32'(wcnt) + 32'd1) == {16'd0, dcount};

  always_ff @(posedge clock) begin
    if (!reset) state <= S_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    err       = 1'b0;
    case (state)
      S_RUN: begin
        cpu_hold = 1'b0;
        if (start_pg) state_nxt = S_HDR;
      end
      S_HDR: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (byte_last) begin
          if (hdr_bad)                 state_nxt = S_ERR;
          else if (icount != 16'd0)    state_nxt = S_IMEM;
          else if (dcount_hdr != 16'd0) state_nxt = S_DMEM;
          else                         state_nxt = S_DONE;
        end else if (tmo) begin
          state_nxt = S_ERR;
        end
      end
      S_IMEM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (byte_last && last_i) state_nxt = (dcount != 16'd0) ? S_DMEM : S_DONE;
        else if (tmo)            state_nxt = S_ERR;
      end
      S_DMEM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (byte_last && last_d) state_nxt = S_DONE;
        else if (tmo)            state_nxt = S_ERR;
      end
      S_DONE: begin
        load_done = 1'b1;
        state_nxt = S_RUN;
      end
      S_ERR: begin
        err = 1'b1;
        if (start_pg) state_nxt = S_HDR;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Stage p1: byte capture and registered memory write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bidx       <= 2'd0;
      wbuf       <= 24'd0;
      icount     <= 16'd0;
      dcount     <= 16'd0;
      wcnt       <= '0;
      tcnt       <= '0;
      imem_we_p1 <= 1'b0;
      dmem_we_p1 <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= 32'd0;
    end else begin
      imem_we_p1 <= 1'b0;
      dmem_we_p1 <= 1'b0;
      if (state_nxt == S_HDR && state != S_HDR) begin
        bidx   <= 2'd0;
        tcnt   <= '0;
        wcnt   <= '0;
        icount <= 16'd0;
        dcount <= 16'd0;
      end else if (loading) begin
        if (accept) begin
          tcnt <= '0;
          bidx <= bidx + 2'd1;
          if (state == S_HDR) begin
            case (bidx)
              2'd0:    icount[7:0]  <= rx_data;
              2'd1:    icount[15:8] <= rx_data;
              2'd2:    dcount[7:0]  <= rx_data;
              default: dcount[15:8] <= rx_data;
            endcase
          end else begin
            case (bidx)
              2'd0: wbuf[7:0]   <= rx_data;
              2'd1: wbuf[15:8]  <= rx_data;
              2'd2: wbuf[23:16] <= rx_data;
              default: begin
                imem_we_p1 <= (state == S_IMEM);
                dmem_we_p1 <= (state == S_DMEM);
                addr_p1    <= wcnt[ADDR_W-1:0];
                wdata_p1   <= {rx_data, wbuf};
                // Each memory counts its words from 0.
                wcnt       <= (state_nxt != state) ? '0 : wcnt + 1'b1;
              end
            endcase
          end
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  assign imem_we   = imem_we_p1;
  assign dmem_we   = dmem_we_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: scenario tasks with a byte-stream scoreboard model.
module tb_prog_load_ctrl;
  localparam int ADDR_W     = 14;
  localparam int IMEM_WORDS = 16384;
  localparam int DMEM_WORDS = 16384;
  localparam int TIMEOUT    = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start_pg = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_ready, cpu_hold, imem_we, dmem_we, busy, load_done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  prog_load_ctrl #(
    .ADDR_W(ADDR_W), .IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start_pg(start_pg), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .cpu_hold(cpu_hold), .imem_we(imem_we),
    .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .load_done(load_done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          dmem;
    bit          both;
    int          addr;
    logic [31:0] data;
    bit          done;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] stream[$];
  int         checks = 0;
  int         errors = 0;
  bit         loading = 1'b0;
  int         hold_drops = 0;

  always @(negedge clock) begin
    wr_t w;
    if (imem_we || dmem_we) begin
      w.dmem = dmem_we;
      w.both = imem_we && dmem_we;
      w.addr = int'(mem_addr);
      w.data = mem_wdata;
      w.done = load_done;
      wr_q.push_back(w);
    end
    if (loading && !cpu_hold) hold_drops++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start_pg = 1'b1;
    step();
    start_pg = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulses,
                           output bit we_seen, output int waits);
    for (int i = 0; i < gap; i++) begin
      if (pulses && $urandom_range(0, 1) == 1) start_pg = 1'b1;
      step();
      start_pg = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waits    = 0;
    while (!rx_ready && waits < 20) begin
      step();
      waits++;
    end
    if (pulses && $urandom_range(0, 3) == 0) start_pg = 1'b1;
    step();
    start_pg = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    we_seen  = imem_we | dmem_we;
  endtask

  task automatic run_stream(input int maxgap, input bit pulses, input string tag);
    int          ic, dc, k, waits, base, exp_addr;
    bit          we, exp_we, exp_dmem, exp_done;
    logic [31:0] exp_data;
    wr_q.delete();
    hold_drops = 0;
    pulse_start();
    loading = 1'b1;
    ic = int'(stream[0]) | (int'(stream[1]) << 8);
    dc = int'(stream[2]) | (int'(stream[3]) << 8);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], $urandom_range(0, maxgap), pulses, we, waits);
      k = i - 4;
      exp_we = (i >= 4) && (k % 4 == 3);
      checks++;
      if (we !== exp_we || waits != 0) begin
        errors++;
        $display("FAIL %s strobe byte%0d: strobe=%0b waits=%0d, expected strobe=%0b waits=0",
                 tag, i, we, waits, exp_we);
      end
    end
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: load_done=%0b cpu_hold=%0b busy=%0b, expected 1 1 0",
               tag, load_done, cpu_hold, busy);
    end
    loading = 1'b0;
    step();
    checks++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL %s release: cpu_hold=%0b load_done=%0b, expected 0 0",
               tag, cpu_hold, load_done);
    end
    checks++;
    if (hold_drops != 0) begin
      errors++;
      $display("FAIL %s hold: cpu_hold low for %0d cycles during load, expected 0", tag, hold_drops);
    end
    checks++;
    if (wr_q.size() != ic + dc) begin
      errors++;
      $display("FAIL %s wr_count: got %0d writes, expected %0d", tag, wr_q.size(), ic + dc);
    end
    for (int w = 0; w < ic + dc && w < wr_q.size(); w++) begin
      base     = 4 + 4 * w;
      exp_data = {stream[base+3], stream[base+2], stream[base+1], stream[base]};
      exp_dmem = (w >= ic);
      exp_addr = exp_dmem ? w - ic : w;
      exp_done = (w == ic + dc - 1);
      checks++;
      if (wr_q[w].dmem !== exp_dmem || wr_q[w].both || wr_q[w].addr != exp_addr ||
          wr_q[w].data !== exp_data || wr_q[w].done !== exp_done) begin
        errors++;
        $display("FAIL %s wr[%0d]: got dmem=%0b both=%0b addr=%0d data=%h done=%0b, expected dmem=%0b both=0 addr=%0d data=%h done=%0b",
                 tag, w, wr_q[w].dmem, wr_q[w].both, wr_q[w].addr, wr_q[w].data, wr_q[w].done,
                 exp_dmem, exp_addr, exp_data, exp_done);
      end
    end
  endtask

  task automatic build_random(input int ic, input int dc);
    stream.delete();
    stream.push_back(8'(ic));
    stream.push_back(8'(ic >> 8));
    stream.push_back(8'(dc));
    stream.push_back(8'(dc >> 8));
    for (int i = 0; i < 4 * (ic + dc); i++) stream.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({rx_ready, cpu_hold, busy, load_done, err, imem_we, dmem_we} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/hold/busy/done/err/iwe/dwe=%b, expected 0000000",
               {rx_ready, cpu_hold, busy, load_done, err, imem_we, dmem_we});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d data=%h, expected 0 0", mem_addr, mem_wdata);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_full_load();
    stream = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
    run_stream(0, 1'b0, "full_load");
    if (wr_q.size() == 3) begin
      checks++;
      if (wr_q[0].data !== 32'h12345678 || wr_q[1].data !== 32'hDEADBEEF ||
          wr_q[2].data !== 32'h01020304 || wr_q[2].dmem !== 1'b1 || wr_q[1].addr != 1) begin
        errors++;
        $display("FAIL full_load_words: got %h %h %h, expected 12345678 deadbeef 01020304",
                 wr_q[0].data, wr_q[1].data, wr_q[2].data);
      end
    end
  endtask

  task automatic test_header_error();
    logic [7:0] hdr[2][4];
    bit we;
    int waits;
    hdr[0] = '{8'h01, 8'h40, 8'h00, 8'h00};
    hdr[1] = '{8'h00, 8'h00, 8'h01, 8'h40};
    for (int h = 0; h < 2; h++) begin
      wr_q.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(hdr[h][i], 0, 1'b0, we, waits);
      checks++;
      if (err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || we !== 1'b0) begin
        errors++;
        $display("FAIL hdr_err%0d: err=%0b hold=%0b busy=%0b rdy=%0b we=%0b, expected 1 1 0 0 0",
                 h, err, cpu_hold, busy, rx_ready, we);
      end
      repeat (4) step();
      checks++;
      if (err !== 1'b1 || wr_q.size() != 0) begin
        errors++;
        $display("FAIL hdr_err_hold%0d: err=%0b writes=%0d, expected 1 0", h, err, wr_q.size());
      end
      pulse_start();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1) begin
        errors++;
        $display("FAIL hdr_restart%0d: err=%0b busy=%0b rdy=%0b, expected 0 1 1", h, err, busy, rx_ready);
      end
      for (int i = 0; i < 4; i++) send_byte(8'h00, 0, 1'b0, we, waits);
      checks++;
      if (load_done !== 1'b1 || we !== 1'b0) begin
        errors++;
        $display("FAIL hdr_zero%0d: load_done=%0b we=%0b, expected 1 0", h, load_done, we);
      end
      step();
    end
  endtask

  task automatic test_zero_length();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(2, 1'b0, "zero_len");
  endtask

  task automatic test_timeout();
    bit we;
    int waits;
    logic [7:0] hdr[4];
    wr_q.delete();
    pulse_start();
    hdr = '{8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) send_byte(hdr[i], 0, 1'b0, we, waits);
    send_byte(8'hAA, 0, 1'b0, we, waits);
    send_byte(8'hBB, 0, 1'b0, we, waits);
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      step();
      if (i == TIMEOUT - 2) begin
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL tmo_early: err=%0b busy=%0b after %0d idle, expected 0 1", err, busy, i);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_imem: err=%0b hold=%0b writes=%0d, expected 1 1 0", err, cpu_hold, wr_q.size());
    end
    // icount equal to the memory depth is legal; then let it time out.
    pulse_start();
    hdr = '{8'h00, 8'h40, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) send_byte(hdr[i], 0, 1'b0, we, waits);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hdr_max: err=%0b busy=%0b, expected 0 1", err, busy);
    end
    repeat (TIMEOUT - 1) step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_max: err=%0b, expected 1", err);
    end
    pulse_start();
    repeat (TIMEOUT - 2) step();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_hdr_early: err=%0b busy=%0b, expected 0 1", err, busy);
    end
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_hdr: err=%0b, expected 1", err);
    end
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stream(1, 1'b0, "after_tmo");
  endtask

  task automatic test_mid_load_reset();
    bit we;
    int waits;
    logic [7:0] hdr[4];
    wr_q.delete();
    pulse_start();
    hdr = '{8'h01, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) send_byte(hdr[i], 0, 1'b0, we, waits);
    send_byte(8'h5A, 1, 1'b0, we, waits);
    send_byte(8'hA5, 0, 1'b0, we, waits);
    send_byte(8'h3C, 0, 1'b0, we, waits);
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    reset    = 1'b0;
    step();
    reset    = 1'b1;
    rx_valid = 1'b0;
    checks++;
    if ({cpu_hold, busy, rx_ready, imem_we, dmem_we, err} !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset: hold/busy/rdy/iwe/dwe/err=%b, expected 000000",
               {cpu_hold, busy, rx_ready, imem_we, dmem_we, err});
    end
    repeat (3) step();
    checks++;
    if (wr_q.size() != 0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_nowr: writes=%0d hold=%0b, expected 0 0", wr_q.size(), cpu_hold);
    end
  endtask

  task automatic test_ignored_requests();
    stream = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h10, 8'h32, 8'h54, 8'h76,
               8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h01, 8'h23, 8'h45, 8'h67};
    run_stream(3, 1'b1, "ignored_req");
  endtask

  task automatic test_back_to_back();
    build_random(3, 3);
    run_stream(0, 1'b0, "back_to_back");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      build_random($urandom_range(0, 4), $urandom_range(0, 4));
      run_stream($urandom_range(0, 3), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_header_error();
    test_zero_length();
    test_timeout();
    test_mid_load_reset();
    test_ignored_requests();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
